gmm_desc_prefetcher: RTL
========================

Name: gmm_desc_prefetcher

Overview:
Consumer end of the descriptor-RAM and prefetcher-CSR write interface driven by the GMM DMA control sequencer. It holds a 64 x 256-bit descriptor RAM and a small CSR file. When run is set, it walks the descriptor chain and issues one transfer command per descriptor to the downstream dispatcher with a valid/ready handshake. After each transfer it waits for completion and updates the descriptor status.

Parameters:
DESC_DEPTH, 64, descriptor RAM entries (power of 2, ≤64; index width = $clog2(DESC_DEPTH))
DESC_BASE_ADDR, 0, byte address that maps to descriptor index 0
POLL_DEFAULT, 16'd256, reset value of poll interval in cycles

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ram_write  in  1  descriptor RAM write strobe
ram_writedata  in  256  descriptor word
ram_addr  in  6  descriptor index
pref_write  in  1  CSR write strobe
pref_writedata  in  32  CSR data
pref_addr  in  3  CSR address
cmd_valid  out  1  command valid
cmd_ready  in  1  dispatcher accepts command
cmd_read_addr  out  32  descriptor read_addr
cmd_write_addr  out  32  descriptor write_addr
cmd_length  out  32  descriptor length
cmd_control  out  32  descriptor control word
resp_valid  in  1  one-cycle transfer-done pulse
resp_bytes  in  32  actual bytes transferred
resp_error  in  8  error code
irq  out  1  level interrupt
busy  out  1  FSM not in IDLE
cur_index  out  6  index being processed

Behaviour:
- Reset: asynchronous, active-high (rst); clk is the only clock. Reset clears all outputs to 0 and all CSRs to 0, except poll = POLL_DEFAULT. RAM contents are undefined after reset.
- Descriptor layout, bit ranges of the 256-bit word:
  - control [255:224]: go=31, owned_by_hw=30, transfer_complete_irq_en=14, transmit_ch=[7:0]
  - [223:176] reserved; status [175:160]; actual_bytes [159:128]
  - next_desc_ptr [127:96]; length [95:64]; write_addr [63:32]; read_addr [31:0]
- CSR map (writes take effect the next cycle):
  - 0 control: run=0, desc_poll_en=1, reset_prefetcher=2, global_irq_en=3, pack_mode=4 (pack_mode stored only)
  - 1 start_ptr[31:0]
  - 2 start_ptr_hi (stored, ignored)
  - 3 poll[15:0]
  - 4–7 writes ignored
- Pointer-to-index mapping: index = ((ptr - DESC_BASE_ADDR) >> 5) mod DESC_DEPTH. Pointer bits [4:0] are ignored.
- RAM: dual-port. Port A is the host write. Port B is the FSM read/write, with 1-cycle read latency. On a same-index, same-cycle collision, the host write wins and the port-B write is dropped.
- FSM states:
  - IDLE: on run 0->1 seen, load cur_index from start_ptr -> FETCH.
  - FETCH: issue port-B read -> CHECK (data valid in CHECK).
  - CHECK:
    - If go=1 and owned_by_hw=1: register the fields -> ISSUE.
    - Otherwise, if desc_poll_en=1: -> POLL.
    - Otherwise: clear run -> IDLE.
  - POLL: count poll cycles; poll=0 is treated as 1 -> FETCH.
  - ISSUE: cmd_valid=1 and cmd_* stable until cmd_ready; the handshake completes on the valid&ready cycle -> WAIT.
  - WAIT: on resp_valid -> WB, with status = {8'h0, resp_error}.
    - resp_valid outside WAIT is ignored.
    - resp_valid in the same cycle as the ISSUE handshake is ignored.
  - WB: write back the descriptor (see feature) -> NEXT.
  - NEXT: cur_index <= map(next_desc_ptr) -> FETCH, or -> IDLE if run=0.
- irq: set in WB when transfer_complete_irq_en=1, global_irq_en=1, and resp_error != 0 or the transfer completes. Cleared by a CSR write to address 0 with bit 3 = 0.
- Clearing run mid-chain: the current descriptor completes, then the FSM stops at NEXT.
- reset_prefetcher=1 (self-clearing):
  - In ISSUE, it is deferred until the handshake completes.
  - Otherwise the FSM goes to IDLE the next cycle, and run and irq are cleared.
  - A resp_valid that arrives after an abort is ignored.
- Index wrap: the index is modulo DESC_DEPTH; no range error is raised.

Optional Feature:
GMM_PREF_WRITEBACK_EN
- Defined: WB writes actual_bytes=resp_bytes and status, and clears owned_by_hw, then takes 1 cycle. The chain stops at a descriptor the host has not re-armed, or polls it if desc_poll_en=1.
- Undefined: WB is a no-op 1-cycle pass-through and the RAM is never written by port B. A circular chain therefore repeats forever.

Decomposition:
- Package gmm_dma_pkg: desc_control_t, pref_standart_desc_t, pref_control_t, CSR address constants, and DESC_BYTES=32.
- Sub-module gmm_desc_ram: simple dual-port 256-bit RAM with the collision rule above.

Test Plan:
1. Write 4 descriptors chained 0->1->2->3->0 (go=1, owned=1, lengths 32/64/32/64). Write CSR1=0, then CSR0=0x11. Expect cmd order 0,1,2,3 with matching length and read_addr.
2. Write-back enabled, same chain, resp_bytes=len: after the 4th resp, expect FSM IDLE, run=0, and RAM[0].owned_by_hw=0 with actual_bytes=32.
3. Hold cmd_ready=0 for 10 cycles. Expect cmd_valid held high and fields stable; cmd accepted on the first ready cycle.
4. Descriptor 1 with owned=0 and desc_poll_en=1, poll=5. Expect a re-fetch every 7 cycles. Host re-arms entry 1 -> its cmd is issued.
5. transfer_complete_irq_en=1 and global_irq_en=1, resp_error=8'h04. Expect irq=1 and status=0x0004; CSR0 write with bit 3 = 0 clears irq.
6. Assert rst during WAIT. Expect all outputs 0 immediately, and a later resp_valid has no effect.

Source files
------------

// File: rtl/gmm_dma_pkg.sv
// Shared types, CSR map and helpers for the GMM DMA descriptor prefetcher.
package gmm_dma_pkg;

    localparam int DESC_BYTES = 32;
    localparam int DESC_W     = 256;

    localparam logic [2:0] CSR_CONTROL      = 3'd0;
    localparam logic [2:0] CSR_START_PTR    = 3'd1;
    localparam logic [2:0] CSR_START_PTR_HI = 3'd2;
    localparam logic [2:0] CSR_POLL         = 3'd3;

    typedef struct packed {
        logic        go;
        logic        owned_by_hw;
        logic [14:0] rsvd_hi;
        logic        transfer_complete_irq_en;
        logic [5:0]  rsvd_lo;
        logic [7:0]  transmit_ch;
    } desc_control_t;

    typedef struct packed {
        desc_control_t control;
        logic [47:0]   reserved;
        logic [15:0]   status;
        logic [31:0]   actual_bytes;
        logic [31:0]   next_desc_ptr;
        logic [31:0]   length;
        logic [31:0]   write_addr;
        logic [31:0]   read_addr;
    } pref_standart_desc_t;

    typedef struct packed {
        logic [26:0] rsvd;
        logic        pack_mode;
        logic        global_irq_en;
        logic        reset_prefetcher;
        logic        desc_poll_en;
        logic        run;
    } pref_control_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CHECK,
        ST_POLL,
        ST_ISSUE,
        ST_WAIT,
        ST_WB,
        ST_NEXT
    } pref_state_e;

    // Byte pointer to descriptor slot; the caller truncates to its RAM depth.
    function automatic logic [5:0] desc_index_of(input logic [31:0] ptr, input logic [31:0] base);
        return 6'((ptr - base) >> $clog2(DESC_BYTES));
    endfunction

endpackage

// File: rtl/gmm_desc_ram.sv
// Simple dual-port descriptor RAM: port A is the host write, port B the sequencer
// read/write with one-cycle read latency. A same-index collision drops the port-B write.
module gmm_desc_ram #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             a_we,
    input  logic [IDX_W-1:0] a_addr,
    input  logic [255:0]     a_wdata,
    input  logic             b_re,
    input  logic             b_we,
    input  logic [IDX_W-1:0] b_addr,
    input  logic [255:0]     b_wdata,
    output logic [255:0]     b_rdata
);

    logic [255:0] mem_q [DEPTH];
    logic [255:0] rdata_q;
    logic         b_we_eff;

    assign b_we_eff = b_we && !(a_we && (a_addr == b_addr));
    assign b_rdata  = rdata_q;

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem_q[a_addr] <= a_wdata;
        end
        if (b_we_eff) begin
            mem_q[b_addr] <= b_wdata;
        end
        if (b_re) begin
            rdata_q <= mem_q[b_addr];
        end
    end

endmodule

// File: rtl/gmm_desc_prefetcher.sv
// Descriptor-chain prefetcher: CSR file, descriptor RAM and the sequencer that issues
// one dispatcher command per descriptor. Descriptor write-back is enabled by GMM_PREF_WRITEBACK_EN.
module gmm_desc_prefetcher #(
    parameter int          DESC_DEPTH     = 64,
    parameter logic [31:0] DESC_BASE_ADDR = 32'd0,
    parameter logic [15:0] POLL_DEFAULT   = 16'd256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ram_write,
    input  logic [255:0] ram_writedata,
    input  logic [5:0]   ram_addr,
    input  logic         pref_write,
    input  logic [31:0]  pref_writedata,
    input  logic [2:0]   pref_addr,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic [31:0]  cmd_read_addr,
    output logic [31:0]  cmd_write_addr,
    output logic [31:0]  cmd_length,
    output logic [31:0]  cmd_control,
    input  logic         resp_valid,
    input  logic [31:0]  resp_bytes,
    input  logic [7:0]   resp_error,
    output logic         irq,
    output logic         busy,
    output logic [5:0]   cur_index
);
    import gmm_dma_pkg::*;

    localparam int IDX_W = $clog2(DESC_DEPTH);

    pref_state_e         state_q, state_d;
    logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
    logic                run_q, run_d;
    logic                run_prev_q, run_prev_d;
    logic                poll_en_q, poll_en_d;
    logic                rp_q, rp_d;
    logic                gie_q, gie_d;
    logic                pack_q, pack_d;
    logic [31:0]         start_ptr_q, start_ptr_d;
    logic [31:0]         start_hi_q, start_hi_d;
    logic [15:0]         poll_q, poll_d;
    logic [15:0]         poll_cnt_q, poll_cnt_d;
    logic                irq_q, irq_d;
    pref_standart_desc_t desc_q, desc_d;
    logic [15:0]         status_q, status_d;
    logic [31:0]         act_bytes_q, act_bytes_d;

    pref_standart_desc_t desc_rd;
    pref_standart_desc_t wb_word;
    pref_control_t       wr_ctrl;
    logic [255:0]        ram_rdata;
    logic                ram_b_re;
    logic                ram_b_we;
    logic [15:0]         poll_last;
    logic                abort;
    logic                fsm_clr_run;
    logic                set_irq;
    logic                unused_ok;

    gmm_desc_ram #(
        .DEPTH (DESC_DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .a_we    (ram_write),
        .a_addr  (ram_addr[IDX_W-1:0]),
        .a_wdata (ram_writedata),
        .b_re    (ram_b_re),
        .b_we    (ram_b_we),
        .b_addr  (cur_idx_q),
        .b_wdata (wb_word),
        .b_rdata (ram_rdata)
    );

    assign desc_rd   = pref_standart_desc_t'(ram_rdata);
    assign wr_ctrl   = pref_control_t'(pref_writedata);
    assign poll_last = (poll_q == 16'd0) ? 16'd0 : poll_q - 16'd1;
    assign ram_b_re  = (state_q == ST_FETCH);

    always_comb begin
        wb_word                     = desc_q;
        wb_word.control.owned_by_hw = 1'b0;
        wb_word.status              = status_q;
        wb_word.actual_bytes        = act_bytes_q;
    end

`ifdef GMM_PREF_WRITEBACK_EN
    assign ram_b_we = (state_q == ST_WB);
`else
    assign ram_b_we = 1'b0;
`endif

    // Sequencer. A pending reset_prefetcher aborts any state except ISSUE, so an
    // offered command is never withdrawn before the dispatcher takes it.
    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        poll_cnt_d  = poll_cnt_q;
        desc_d      = desc_q;
        status_d    = status_q;
        act_bytes_d = act_bytes_q;
        abort       = 1'b0;
        fsm_clr_run = 1'b0;
        set_irq     = 1'b0;

        if (rp_q && (state_q != ST_ISSUE)) begin
            abort   = 1'b1;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_q && !run_prev_q) begin
                        cur_idx_d = IDX_W'(desc_index_of(start_ptr_q, DESC_BASE_ADDR));
                        state_d   = ST_FETCH;
                    end
                end
                ST_FETCH: state_d = ST_CHECK;
                ST_CHECK: begin
                    if (desc_rd.control.go && desc_rd.control.owned_by_hw) begin
                        desc_d  = desc_rd;
                        state_d = ST_ISSUE;
                    end else if (poll_en_q) begin
                        poll_cnt_d = 16'd0;
                        state_d    = ST_POLL;
                    end else begin
                        fsm_clr_run = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                ST_POLL: begin
                    if (poll_cnt_q == poll_last) begin
                        state_d = ST_FETCH;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (resp_valid) begin
                        status_d    = {8'h00, resp_error};
                        act_bytes_d = resp_bytes;
                        state_d     = ST_WB;
                    end
                end
                ST_WB: begin
                    set_irq = desc_q.control.transfer_complete_irq_en && gie_q;
                    state_d = ST_NEXT;
                end
                ST_NEXT: begin
                    if (run_q) begin
                        cur_idx_d = IDX_W'(desc_index_of(desc_q.next_desc_ptr, DESC_BASE_ADDR));
                        state_d   = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // CSR file. Host writes land after sequencer-side clears; an irq raised in WB
    // beats a simultaneous host clear so no completion is lost.
    always_comb begin
        run_d       = run_q;
        run_prev_d  = run_q;
        poll_en_d   = poll_en_q;
        rp_d        = rp_q;
        gie_d       = gie_q;
        pack_d      = pack_q;
        start_ptr_d = start_ptr_q;
        start_hi_d  = start_hi_q;
        poll_d      = poll_q;
        irq_d       = irq_q;

        if (fsm_clr_run) begin
            run_d = 1'b0;
        end
        if (abort) begin
            run_d = 1'b0;
            rp_d  = 1'b0;
            irq_d = 1'b0;
        end

        if (pref_write) begin
            case (pref_addr)
                CSR_CONTROL: begin
                    run_d     = wr_ctrl.run;
                    poll_en_d = wr_ctrl.desc_poll_en;
                    rp_d      = rp_d | wr_ctrl.reset_prefetcher;
                    gie_d     = wr_ctrl.global_irq_en;
                    pack_d    = wr_ctrl.pack_mode;
                    if (!wr_ctrl.global_irq_en) begin
                        irq_d = 1'b0;
                    end
                end
                CSR_START_PTR:    start_ptr_d = pref_writedata;
                CSR_START_PTR_HI: start_hi_d  = pref_writedata;
                CSR_POLL:         poll_d      = pref_writedata[15:0];
                default: ;
            endcase
        end

        if (set_irq) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_idx_q   <= '0;
            run_q       <= 1'b0;
            run_prev_q  <= 1'b0;
            poll_en_q   <= 1'b0;
            rp_q        <= 1'b0;
            gie_q       <= 1'b0;
            pack_q      <= 1'b0;
            start_ptr_q <= '0;
            start_hi_q  <= '0;
            poll_q      <= POLL_DEFAULT;
            poll_cnt_q  <= '0;
            irq_q       <= 1'b0;
            desc_q      <= '0;
            status_q    <= '0;
            act_bytes_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            run_q       <= run_d;
            run_prev_q  <= run_prev_d;
            poll_en_q   <= poll_en_d;
            rp_q        <= rp_d;
            gie_q       <= gie_d;
            pack_q      <= pack_d;
            start_ptr_q <= start_ptr_d;
            start_hi_q  <= start_hi_d;
            poll_q      <= poll_d;
            poll_cnt_q  <= poll_cnt_d;
            irq_q       <= irq_d;
            desc_q      <= desc_d;
            status_q    <= status_d;
            act_bytes_q <= act_bytes_d;
        end
    end

    // Handshake: cmd_* come straight from the descriptor register, so they hold
    // steady for as long as cmd_valid is high; the transfer happens on valid & ready.
    assign cmd_valid      = (state_q == ST_ISSUE);
    assign cmd_read_addr  = desc_q.read_addr;
    assign cmd_write_addr = desc_q.write_addr;
    assign cmd_length     = desc_q.length;
    assign cmd_control    = desc_q.control;
    assign irq            = irq_q;
    assign busy           = (state_q != ST_IDLE);
    assign cur_index      = 6'(cur_idx_q);

    assign unused_ok = ^{pack_q, start_hi_q, wr_ctrl.rsvd, ram_addr};

endmodule
